lcd_hex_frame_ctrl: RTL
=======================

// Module: lcd_hex_frame_ctrl
// PURPOSE
//  Parametrised HD44780 character-LCD controller; next generation of the fixed PC/OPCODE/DATA LCD display.
//  Holds a ROWS x COLS character frame buffer that the CPU side fills with hex fields at any (row, col).
//  Runs the power-up/init sequence itself, then streams the frame to the panel whenever it changes.
//  Sits between the processor debug/IO write path and the DE2 LCD pins.
// PARAMETERS
//  ROWS          2       display lines (1..4); line base addresses 0x00,0x40,0x14,0x54
//  COLS          16      characters per line (1..20)
//  POWERUP_CYC   750000  wait after reset before first command (15 ms @ 50 MHz)
//  E_PULSE_CYC   16      LCD_E high time in cycles
//  CHAR_WAIT_CYC 2500    post-command/char wait (50 us)
//  CLR_WAIT_CYC  100000  post-clear (0x01) wait (2 ms)
// PORTS
//  iCLK_50MHZ  in   1                clock
//  iRST_N      in   1                async active-low reset
//  iWR         in   1                write request; accepted when iWR && oREADY
//  iROW        in   $clog2(ROWS)+1   target line (>=ROWS: request dropped, still accepted)
//  iCOL        in   5                first column of field
//  iVAL        in   32               value to render in hex
//  iNDIG       in   4                hex digits to render (0->1, >8->8)
//  oREADY      out  1                high when a write can be accepted
//  oINIT_DONE  out  1                high once init sequence completed
//  LCD_ON      out  1                constant 1
//  LCD_BLON    out  1                constant 1
//  LCD_RW      out  1                constant 0 (write only)
//  LCD_RS      out  1                0 command, 1 data
//  LCD_E       out  1                enable strobe
//  LCD_DATA    out  8                data bus
// BEHAVIOUR
//  Reset (async): LCD_E=0, LCD_RS=0, LCD_DATA=0, oINIT_DONE=0, oREADY=1, dirty=1, frame all 0x20; FSM->PWRUP.
//  Reset mid-transfer: LCD_E drops same instant; init sequence reruns in full.
//  Write: on accept, latch fields; oREADY=0 for N=clamped iNDIG cycles, one digit written per cycle,
//   MS digit (iVAL[4N-1:4N-4]) at iCOL, then iCOL+1...; oREADY=1 the cycle after last digit; dirty<=1.
//  Digit ASCII: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase). Digits with col>=COLS dropped, no wrap.
//  Writes accepted in any FSM state, including PWRUP/INIT and mid-refresh.
//  Byte transfer: cycle 0 drive RS/DATA with E=0; E=1 for E_PULSE_CYC; E=0 then wait CHAR_WAIT_CYC
//   (CLR_WAIT_CYC after 0x01); RS/DATA held stable until wait ends.
//  FSM: PWRUP(POWERUP_CYC) -> INIT(0x38,0x0C,0x01,0x06 in order) -> oINIT_DONE=1 -> IDLE.
//   IDLE: dirty -> clear dirty, row=0 -> ADDR (cmd 0x80|base[row]) -> CHAR x COLS (RS=1) -> next row
//   or IDLE after last row.
//  Write landing during refresh sets dirty again: current pass completes, a second full pass follows.
//  Refresh never reads a half-written field: frame is sampled per character at CHAR start.
// CONFIGURATION
//  LCD_AUTO_REFRESH_EN defined: IDLE re-enters refresh unconditionally (continuous redraw, dirty ignored).
//  Undefined: refresh only when dirty; panel bus idle (E=0) otherwise.
// TESTING
//  (Small timing params: POWERUP_CYC=20, E_PULSE_CYC=2, CHAR_WAIT_CYC=4, CLR_WAIT_CYC=10.)
//  Reset release -> 4 E pulses RS=0 DATA 0x38,0x0C,0x01,0x06; oINIT_DONE rises after last wait; then 0x80 + 16 x 0x20, 0xC0 + 16 x 0x20.
//  Write row0 col0 iVAL=0x0040_1A2F iNDIG=8 -> oREADY low 8 cycles; line0 streams "00401A2F" then 8 spaces.
//  Write row1 col14 iVAL=0xABCD iNDIG=4 -> only "AB" at cols 14,15; no wrap into row0 or col0.
//  Write during char 5 of row1 refresh -> current pass finishes, second full pass carries new data.
//  Assert iRST_N low while LCD_E=1 -> LCD_E=0 immediately; after release init replays from 0x38, frame blank.
//  Without LCD_AUTO_REFRESH_EN: no E pulses after last pass until next write; with it: passes back-to-back.

Source files
------------

// File: rtl/lcd_hex_frame_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_hex_frame_ctrl
//
// HD44780 character-LCD controller with a ROWS x COLS character frame buffer.
// The CPU side drops hex fields into the frame at any (row, col). The
// controller runs the panel power-up/init sequence itself. After that it
// streams the whole frame to the panel each time the frame changes.
//
// Parameters
//   ROWS          display lines (1..4), line bases 0x00, 0x40, 0x14, 0x54
//   COLS          characters per line (1..20)
//   POWERUP_CYC   wait after reset before the first command
//   E_PULSE_CYC   LCD_E high time in clock cycles
//   CHAR_WAIT_CYC wait after each command/character byte
//   CLR_WAIT_CYC  wait after the clear-display command (0x01)
//
// Ports
//   iCLK_50MHZ  clock
//   iRST_N      asynchronous active-low reset
//   iWR         write request, taken when iWR && oREADY
//   iROW        target line (rows >= ROWS are accepted but discarded)
//   iCOL        column of the most significant digit
//   iVAL        value to render in hex
//   iNDIG       number of hex digits (0 is treated as 1, >8 as 8)
//   oREADY      high when a write can be accepted
//   oINIT_DONE  high once the panel init sequence has completed
//   LCD_ON, LCD_BLON, LCD_RW   static panel controls (1, 1, 0)
//   LCD_RS      0 = command byte, 1 = character byte
//   LCD_E       enable strobe
//   LCD_DATA    8-bit panel data bus
//
// Build option
//   LCD_AUTO_REFRESH_EN  when defined, the frame is redrawn continuously and
//                        the dirty flag is ignored. When undefined, a redraw
//                        runs only after the frame has changed.
// ---------------------------------------------------------------------------
module lcd_hex_frame_ctrl #(
    parameter int ROWS          = 2,
    parameter int COLS          = 16,
    parameter int POWERUP_CYC   = 750000,
    parameter int E_PULSE_CYC   = 16,
    parameter int CHAR_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC  = 100000
) (
    input  logic                  iCLK_50MHZ,
    input  logic                  iRST_N,
    input  logic                  iWR,
    input  logic [$clog2(ROWS):0] iROW,
    input  logic [4:0]            iCOL,
    input  logic [31:0]           iVAL,
    input  logic [3:0]            iNDIG,
    output logic                  oREADY,
    output logic                  oINIT_DONE,
    output logic                  LCD_ON,
    output logic                  LCD_BLON,
    output logic                  LCD_RW,
    output logic                  LCD_RS,
    output logic                  LCD_E,
    output logic [7:0]            LCD_DATA
);

    // Width of the external row port, and the index widths of the frame buffer.
    localparam int RIW = $clog2(ROWS) + 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LR  = ROWS - 1;
    localparam int LC  = COLS - 1;

    localparam logic [RIW-1:0] ROWS_L   = ROWS[RIW-1:0];
    localparam logic [5:0]     COLS_L   = COLS[5:0];
    localparam logic [RW-1:0]  LAST_ROW = LR[RW-1:0];
    localparam logic [CW-1:0]  LAST_COL = LC[CW-1:0];

    localparam logic [31:0] PWR_LAST = POWERUP_CYC - 1;
    localparam logic [31:0] E_LAST   = E_PULSE_CYC - 1;
    localparam logic [31:0] CHR_LAST = CHAR_WAIT_CYC - 1;
    localparam logic [31:0] CLR_LAST = CLR_WAIT_CYC - 1;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHAR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } phase_t;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hexAscii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // DDRAM base address of each display line.
    function automatic logic [7:0] lineBase(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    // Power-on command list: function set, display on, clear, entry mode.
    function automatic logic [7:0] initCmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    logic [7:0]    frame_q [ROWS][COLS];
    logic          wrBusy_q;
    logic          ready_q;
    logic          wrRowOk_q;
    logic [RW-1:0] wrRow_q;
    logic [5:0]    wrCol_q;
    logic [31:0]   wrVal_q;
    logic [3:0]    wrN_q;
    logic [3:0]    wrIdx_q;

    logic [3:0]    ndig_d;
    logic [31:0]   valAligned_d;
    logic          wrAccept_d;
    logic          wrLast_d;
    logic          wrHit_d;
    logic [7:0]    wrChar_d;

    // Clamp the digit count. Left-align the value so the most significant
    // digit to render sits in bits [31:28]. The write path then shifts left
    // by one nibble per cycle. The column counter is 6 bits wide, so a field
    // that starts near column 31 runs off the end and is dropped. It does
    // not wrap back to column 0.
    always_comb begin
        ndig_d = iNDIG;
        if (iNDIG == 4'd0) begin
            ndig_d = 4'd1;
        end else if (iNDIG > 4'd8) begin
            ndig_d = 4'd8;
        end
        valAligned_d = iVAL << {4'd8 - ndig_d, 2'b00};
        wrAccept_d   = iWR && ready_q;
        wrLast_d     = wrBusy_q && (wrIdx_q == wrN_q - 4'd1);
        wrHit_d      = wrBusy_q && wrRowOk_q && (wrCol_q < COLS_L);
        wrChar_d     = hexAscii(wrVal_q[31:28]);
    end

    // Field writer: latch the request, then commit one digit per cycle
    // into the frame buffer. oREADY is low while digits are being committed.
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    frame_q[r][c] <= 8'h20;
                end
            end
            wrBusy_q  <= 1'b0;
            ready_q   <= 1'b1;
            wrRowOk_q <= 1'b0;
            wrRow_q   <= '0;
            wrCol_q   <= '0;
            wrVal_q   <= '0;
            wrN_q     <= 4'd1;
            wrIdx_q   <= '0;
        end else if (wrAccept_d) begin
            wrBusy_q  <= 1'b1;
            ready_q   <= 1'b0;
            wrRowOk_q <= (iROW < ROWS_L);
            wrRow_q   <= iROW[RW-1:0];
            wrCol_q   <= {1'b0, iCOL};
            wrVal_q   <= valAligned_d;
            wrN_q     <= ndig_d;
            wrIdx_q   <= '0;
        end else if (wrBusy_q) begin
            if (wrHit_d) begin
                frame_q[wrRow_q][wrCol_q[CW-1:0]] <= wrChar_d;
            end
            wrVal_q <= {wrVal_q[27:0], 4'h0};
            wrCol_q <= wrCol_q + 6'd1;
            wrIdx_q <= wrIdx_q + 4'd1;
            if (wrLast_d) begin
                wrBusy_q <= 1'b0;
                ready_q  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Panel sequencer
    // ------------------------------------------------------------------
    state_t        state_q;
    phase_t        phase_q;
    logic [31:0]   cnt_q;
    logic [1:0]    initIdx_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          dirty_q;
    logic          initDone_q;
    logic          lcdE_q;
    logic          lcdRs_q;
    logic [7:0]    lcdData_q;

    logic [31:0]   waitLast_d;
    logic [RW-1:0] rowInc_d;
    logic [CW-1:0] colInc_d;
    logic          idleGo_d;

    // The clear command needs the long wait. Every other byte uses the
    // short one.
    always_comb begin
        waitLast_d = CHR_LAST;
        if (!lcdRs_q && (lcdData_q == 8'h01)) begin
            waitLast_d = CLR_LAST;
        end
        rowInc_d = row_q + 1'b1;
        colInc_d = col_q + 1'b1;
`ifdef LCD_AUTO_REFRESH_EN
        idleGo_d = 1'b1;
`else
        idleGo_d = dirty_q;
`endif
    end

    // Main sequencer. Each byte transfer has three phases: a setup cycle
    // with E low, E_PULSE_CYC cycles with E high, and a wait with E low.
    // RS and DATA are held through all three phases. They change only at
    // the edge that starts the next byte. Characters are read from the frame
    // at that edge, so a field being written is never seen half-updated.
    // A digit committed during a refresh sets dirty again. The set is placed
    // after the clear in IDLE, so it wins when both happen on the same edge.
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_PWRUP;
            phase_q    <= PH_SETUP;
            cnt_q      <= '0;
            initIdx_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            dirty_q    <= 1'b1;
            initDone_q <= 1'b0;
            lcdE_q     <= 1'b0;
            lcdRs_q    <= 1'b0;
            lcdData_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_PWRUP: begin
                    if (cnt_q == PWR_LAST) begin
                        cnt_q     <= '0;
                        state_q   <= ST_INIT;
                        phase_q   <= PH_SETUP;
                        initIdx_q <= 2'd0;
                        lcdRs_q   <= 1'b0;
                        lcdData_q <= initCmd(2'd0);
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_IDLE: begin
                    lcdE_q <= 1'b0;
                    if (idleGo_d) begin
                        dirty_q   <= 1'b0;
                        row_q     <= '0;
                        col_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_ADDR;
                        phase_q   <= PH_SETUP;
                        lcdRs_q   <= 1'b0;
                        lcdData_q <= 8'h80 | lineBase(2'd0);
                    end
                end
                default: begin
                    case (phase_q)
                        PH_SETUP: begin
                            lcdE_q  <= 1'b1;
                            cnt_q   <= '0;
                            phase_q <= PH_PULSE;
                        end
                        PH_PULSE: begin
                            if (cnt_q == E_LAST) begin
                                lcdE_q  <= 1'b0;
                                cnt_q   <= '0;
                                phase_q <= PH_WAIT;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        default: begin
                            if (cnt_q == waitLast_d) begin
                                cnt_q   <= '0;
                                phase_q <= PH_SETUP;
                                case (state_q)
                                    ST_INIT: begin
                                        if (initIdx_q == 2'd3) begin
                                            initDone_q <= 1'b1;
                                            state_q    <= ST_IDLE;
                                        end else begin
                                            initIdx_q <= initIdx_q + 2'd1;
                                            lcdData_q <= initCmd(initIdx_q + 2'd1);
                                        end
                                    end
                                    ST_ADDR: begin
                                        state_q   <= ST_CHAR;
                                        col_q     <= '0;
                                        lcdRs_q   <= 1'b1;
                                        lcdData_q <= frame_q[row_q][{CW{1'b0}}];
                                    end
                                    default: begin
                                        if (col_q != LAST_COL) begin
                                            col_q     <= colInc_d;
                                            lcdData_q <= frame_q[row_q][colInc_d];
                                        end else if (row_q != LAST_ROW) begin
                                            row_q     <= rowInc_d;
                                            state_q   <= ST_ADDR;
                                            lcdRs_q   <= 1'b0;
                                            lcdData_q <= 8'h80 | lineBase(2'(rowInc_d));
                                        end else begin
                                            state_q <= ST_IDLE;
                                        end
                                    end
                                endcase
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                    endcase
                end
            endcase
            if (wrLast_d) begin
                dirty_q <= 1'b1;
            end
        end
    end

    assign oREADY     = ready_q;
    assign oINIT_DONE = initDone_q;
    assign LCD_ON     = 1'b1;
    assign LCD_BLON   = 1'b1;
    assign LCD_RW     = 1'b0;
    assign LCD_RS     = lcdRs_q;
    assign LCD_E      = lcdE_q;
    assign LCD_DATA   = lcdData_q;

endmodule
